serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor that computes D = A - B as A + ~B + 1.
- Uses a single 4-bit carry-lookahead slice, iterated one nibble per clock from LSB to MSB, with the carry held in a register between nibbles.
- Valid/ready handshake on both input and output.
- Provides the subtract direction alongside the existing combinational 8-bit adder, and is sized for area-constrained datapaths where one CLA slice is shared.

Parameters:
- WIDTH, 8, operand/result width in bits. Must be a multiple of 4 and at least 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands A and B are presented
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  WIDTH  minuend, sampled on acceptance
- B  input  WIDTH  subtrahend, sampled on acceptance
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  downstream consumes the result
- diff  output  WIDTH  A - B modulo 2^WIDTH
- borrow  output  1  1 when A < B (unsigned), i.e. inverted final carry
- overflow  output  1  signed two's-complement overflow
- zero  output  1  diff == 0

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, diff=0, borrow=0, overflow=0, zero=0, state=IDLE, nibble index=0, carry register=0.
- States:
  - IDLE: in_ready=1. On the edge where in_valid & in_ready: latch A and ~B, set carry=1, clear index and the diff accumulator, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge:
    - slice computes A[4i+3:4i] + ~B[4i+3:4i] + carry with lookahead carries;
    - the 4-bit sum is written into diff[4i+3:4i];
    - carry <= slice carry-out;
    - i <= i+1.
    - After the edge processing nibble N-1 (N = WIDTH/4): register borrow = ~carry_out, overflow = (A[msb] != B[msb]) & (diff[msb] != A[msb]), zero = (full diff == 0), then go to DONE.
  - DONE: out_valid=1. diff and all flags are held stable while out_ready=0. On an edge with out_valid & out_ready, go to IDLE with out_valid=0. diff and flags keep their values until the next result overwrites them.
- Latency:
  - out_valid rises N clocks after the accepting edge (2 for WIDTH=8).
  - Throughput is one result per N+2 cycles, minimum.
  - No overlap: the next operand pair is not accepted in the cycle the result is consumed. in_ready goes high the cycle after.
- Ignored inputs:
  - A, B and in_valid are ignored outside IDLE.
  - out_ready is ignored outside DONE.
- Width rules:
  - diff wraps modulo 2^WIDTH.
  - The carry chain between nibbles passes only through the carry register; there is no combinational path from A/B to diff.
- Reset mid-operation: rst in RUN or DONE aborts immediately, returns to IDLE with reset values. No out_valid is produced for the aborted operation.
- Simultaneous rst and in_valid: rst wins, nothing is accepted.
- Unknown or illegal state encoding: return to IDLE.

Test Plan (WIDTH=8):
- A=0x35, B=0x12 -> after 2 clocks out_valid=1, diff=0x23, borrow=0, overflow=0, zero=0.
- A=0x10, B=0x01 -> diff=0x0F, borrow=0. Checks borrow propagation across the nibble boundary through the carry register.
- A=0x12, B=0x35 -> diff=0xDD, borrow=1, overflow=0. Then A=0x80, B=0x01 -> diff=0x7F, overflow=1, borrow=0.
- A=0x5A, B=0x5A -> diff=0x00, zero=1, borrow=0. Then A=0x00, B=0xFF -> diff=0x01, borrow=1, zero=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> diff and flags unchanged, in_ready=0 throughout. Assert out_ready -> out_valid drops next edge and in_ready=1. A second in_valid pulse during RUN is not accepted.
- Assert rst for one cycle in RUN during A=0x35, B=0x12 -> all outputs return to reset values and no out_valid appears. Then A=0x01, B=0x02 -> diff=0xFF, borrow=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: D = A + ~B + 1, one 4-bit carry-lookahead slice per clock, LSB nibble first.
// The inter-nibble carry lives only in carryQ, so there is no combinational path from A/B to diff.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           stateQ, stateD;
    logic [WIDTH-1:0] aQ, aD;
    logic [WIDTH-1:0] nbQ, nbD;
    logic             carryQ, carryD;
    logic [IW-1:0]    idxQ, idxD;
    logic [WIDTH-1:0] accQ, accD;
    logic [WIDTH-1:0] diffQ, diffD;
    logic             borrowQ, borrowD;
    logic             overflowQ, overflowD;
    logic             zeroQ, zeroD;

    logic [3:0]       aNib, bNib;
    logic [3:0]       gen, prop, carries, sumNib;
    logic             carryOut;
    logic [WIDTH-1:0] accNext;
    logic             lastNib;

    // Shared CLA slice: operands selected by the nibble index, carries computed in parallel
    always_comb begin
        aNib    = 4'd0;
        bNib    = 4'd0;
        accNext = accQ;
        for (int k = 0; k < N; k++) begin
            if (idxQ == IW'(k)) begin
                aNib = aQ[4*k +: 4];
                bNib = nbQ[4*k +: 4];
            end
        end
        gen        = aNib & bNib;
        prop       = aNib ^ bNib;
        carries[0] = carryQ;
        carries[1] = gen[0] | (prop[0] & carryQ);
        carries[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carryQ);
        carries[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                   | (prop[2] & prop[1] & prop[0] & carryQ);
        carryOut   = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                   | (prop[3] & prop[2] & prop[1] & gen[0])
                   | (prop[3] & prop[2] & prop[1] & prop[0] & carryQ);
        sumNib     = prop ^ carries;
        for (int k = 0; k < N; k++) begin
            if (idxQ == IW'(k)) begin
                accNext[4*k +: 4] = sumNib;
            end
        end
        lastNib = (idxQ == IW'(N - 1));
    end

    always_comb begin
        stateD    = stateQ;
        aD        = aQ;
        nbD       = nbQ;
        carryD    = carryQ;
        idxD      = idxQ;
        accD      = accQ;
        diffD     = diffQ;
        borrowD   = borrowQ;
        overflowD = overflowQ;
        zeroD     = zeroQ;
        case (stateQ)
            IDLE: begin
                if (in_valid) begin
                    aD     = A;
                    nbD    = ~B;
                    carryD = 1'b1;
                    idxD   = '0;
                    accD   = '0;
                    stateD = RUN;
                end
            end
            RUN: begin
                accD   = accNext;
                carryD = carryOut;
                idxD   = idxQ + IW'(1);
                // Result and flags are published only once the whole word is assembled
                if (lastNib) begin
                    idxD      = '0;
                    diffD     = accNext;
                    borrowD   = ~carryOut;
                    overflowD = (aQ[WIDTH-1] != ~nbQ[WIDTH-1]) && (accNext[WIDTH-1] != aQ[WIDTH-1]);
                    zeroD     = (accNext == '0);
                    stateD    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateD = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= IDLE;
            aQ        <= '0;
            nbQ       <= '0;
            carryQ    <= 1'b0;
            idxQ      <= '0;
            accQ      <= '0;
            diffQ     <= '0;
            borrowQ   <= 1'b0;
            overflowQ <= 1'b0;
            zeroQ     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            aQ        <= aD;
            nbQ       <= nbD;
            carryQ    <= carryD;
            idxQ      <= idxD;
            accQ      <= accD;
            diffQ     <= diffD;
            borrowQ   <= borrowD;
            overflowQ <= overflowD;
            zeroQ     <= zeroD;
        end
    end

    assign in_ready  = (stateQ == IDLE);
    assign out_valid = (stateQ == DONE);
    assign diff      = diffQ;
    assign borrow    = borrowQ;
    assign overflow  = overflowQ;
    assign zero      = zeroQ;

endmodule
